// File: rtl/gpio_bank_if.sv
// gpio_bank_if: bus-side connection of the GPIO bank.
// Carries chip select, write strobes, byte address, write data and the
// shared tri-stated read data.
interface gpio_bank_if;
  logic        en;
  logic [2:0]  write_enable;
  logic [31:0] addr;
  logic [31:0] data_in;
  wire  [31:0] data_out;

  modport master (
    output en,
    output write_enable,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  en,
    input  write_enable,
    input  addr,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: parametrised memory-mapped GPIO controller.
// Per-pin 2-flop synchronisers, rising/falling edge detection into a W1C
// STATUS register, registered level irq, and word/half/byte writes.
// Optional input debounce filter is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank #(
  parameter int               WIDTH           = 8,
  parameter logic [WIDTH-1:0] RESET_DIR       = '1,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  gpio_bank_if.slave      bus,
  inout  wire [WIDTH-1:0] gpio,
  output logic            irq
);

  // Register offsets selected by addr[4:2]
  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_DIR     = 3'd1;
  localparam logic [2:0] REG_IN      = 3'd2;
  localparam logic [2:0] REG_IRQ_EN  = 3'd3;
  localparam logic [2:0] REG_RISE_EN = 3'd4;
  localparam logic [2:0] REG_FALL_EN = 3'd5;
  localparam logic [2:0] REG_STATUS  = 3'd6;

  // Programmable state
  logic [WIDTH-1:0] data_lat;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status;

  // Input path
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [1:0]       arm;
  logic             armed;
  logic [WIDTH-1:0] edge_set;

  // Write decode
  logic [2:0]       sel;
  logic             wr_en;
  logic [3:0]       lane_en;
  logic [31:0]      wr_data;
  logic [31:0]      wr_mask;
  logic [WIDTH-1:0] data_w;
  logic [WIDTH-1:0] mask_w;
  logic [WIDTH-1:0] status_clr;

  // Read path
  logic [31:0]      read_word;
  logic             unused_bits;

  assign sel   = bus.addr[4:2];
  assign wr_en = bus.en && (bus.write_enable != 3'b000);

  // Pick the written lanes and replicate half/byte data into every lane so
  // the lane mask alone decides which bits land.
  always_comb begin
    lane_en = 4'b0000;
    wr_data = bus.data_in;
    if (bus.write_enable[0]) begin
      lane_en = 4'b1111;
      wr_data = bus.data_in;
    end else if (bus.write_enable[1]) begin
      lane_en = bus.addr[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{bus.data_in[15:0]}};
    end else if (bus.write_enable[2]) begin
      lane_en = 4'b0001 << bus.addr[1:0];
      wr_data = {4{bus.data_in[7:0]}};
    end
    wr_mask = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
  end

  // Bits at or above WIDTH fall off here.
  assign data_w = wr_data[WIDTH-1:0];
  assign mask_w = wr_mask[WIDTH-1:0];

  assign status_clr = (wr_en && sel == REG_STATUS) ? (data_w & mask_w) : '0;

  assign unused_bits = ^{bus.addr[31:5], wr_data, wr_mask};

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [WIDTH-1:0] val,
                                             input logic [WIDTH-1:0] msk);
    return (old & ~msk) | (val & msk);
  endfunction

  // Pad drivers: output pins follow the data latch, inputs float.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign gpio[i] = dir[i] ? data_lat[i] : 1'bz;
  end

  // Two-flop synchroniser on every pad, edge-detect history and arm counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      arm   <= 2'd0;
    end else begin
      sync1 <= gpio;
      sync2 <= sync1;
      prev  <= filt;
      if (arm != 2'd3) arm <= arm + 2'd1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int               CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] db_cnt [WIDTH];

  // Debounce: filt only follows sync2 after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  assign filt = sync2;
`endif

  // Edges are ignored until the synchronisers have flushed after reset.
  assign armed    = (arm == 2'd3);
  assign edge_set = armed ? ((filt & ~prev & rise_en) | (~filt & prev & fall_en)) : '0;

  // Register file writes, W1C status with set-over-clear, and registered irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_lat <= '0;
      dir      <= RESET_DIR;
      irq_en   <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (sel)
          REG_DATA:    data_lat <= merge(data_lat, data_w, mask_w);
          REG_DIR:     dir      <= merge(dir, data_w, mask_w);
          REG_IRQ_EN:  irq_en   <= merge(irq_en, data_w, mask_w);
          REG_RISE_EN: rise_en  <= merge(rise_en, data_w, mask_w);
          REG_FALL_EN: fall_en  <= merge(fall_en, data_w, mask_w);
          default:     ;
        endcase
      end
      status <= (status & ~status_clr) | edge_set;
      irq    <= |(status & irq_en);
    end
  end

  // Combinational read mux; unimplemented bits and offset 7 read zero.
  always_comb begin
    read_word = '0;
    case (sel)
      REG_DATA:    read_word = 32'(data_lat);
      REG_DIR:     read_word = 32'(dir);
      REG_IN:      read_word = 32'(filt);
      REG_IRQ_EN:  read_word = 32'(irq_en);
      REG_RISE_EN: read_word = 32'(rise_en);
      REG_FALL_EN: read_word = 32'(fall_en);
      REG_STATUS:  read_word = 32'(status);
      default:     read_word = '0;
    endcase
  end

  assign bus.data_out = bus.en ? read_word : {32{1'bz}};

endmodule
